// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: sequencer states, default ADC width and CPU register indices
package adc_seq_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, PUBLISH} seq_state_e;
  localparam int ADC_W_DEFAULT = 8;
  localparam logic [3:0] REG_ADC_VALUE = 4'h2;
  localparam logic [3:0] REG_ADC_READY = 4'h3;
endpackage

// File: rtl/adc_input_sync.sv
// adc_input_sync: two-flop synchronizer for a bus asynchronous to clk_i
module adc_input_sync #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: periodic ADC capture, power-of-two averaging and sticky ready/overrun handshake
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int SAMPLE_DIV = 500,
  parameter int AVG_LOG2   = 2,
  parameter int ADC_W      = ADC_W_DEFAULT
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_in,
  input  logic             ack,
  output logic [31:0]      sample_data,
  output logic             sample_ready,
  output logic             overrun,
  output logic             busy
);
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'((1 << AVG_LOG2) - 1);

  seq_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [31:0]      data_q, data_d;
  logic             ready_q, ready_d, ovr_q, ovr_d;
  logic [ADC_W-1:0] adc_sync;
  logic             run, pub, clr;

  adc_input_sync #(.W(ADC_W)) u_sync (
    .clk_i (clock),
    .rst_ni(ctrl_reset_n),
    .d_i   (adc_in),
    .q_o   (adc_sync)
  );

  // The divider free-runs through CAPTURE/PUBLISH so the sample period never stretches.
  always_comb begin
    run     = enable && state_q != IDLE;
    pub     = enable && state_q == PUBLISH;
    clr     = !enable || state_q == IDLE || pub;
    state_d = !enable ? IDLE :
              state_q == IDLE ? COUNT :
              state_q == CAPTURE ? (n_q == N_LAST ? PUBLISH : COUNT) :
              (state_q == COUNT && div_q == DIV_LAST) ? CAPTURE : COUNT;
    div_d   = (!run || div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    acc_d   = clr ? '0 : state_q == CAPTURE ? acc_q + ACC_W'(adc_sync) : acc_q;
    n_d     = clr ? '0 : state_q == CAPTURE ? n_q + N_W'(1) : n_q;
    data_d  = pub ? 32'(acc_q >> AVG_LOG2) : data_q;
    ready_d = pub || (ready_q && !ack);
    ovr_d   = pub ? (ready_q && !ack) : (ack && ready_q) ? 1'b0 : ovr_q;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_ready = ready_q;
  assign overrun      = ovr_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed vectors, corner sequences and random traffic against a timing-rule model
module tb_adc_sample_sequencer;
  localparam int DIV = 4;
  localparam int AL  = 2;
  localparam int N   = 4;
  localparam int W   = 8;

  logic         clock = 1'b0;
  logic         ctrl_reset_n = 1'b1;
  logic         enable = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] adc_in = '0;
  logic [31:0]  sample_data;
  logic         sample_ready, overrun, busy;

  adc_sample_sequencer #(.SAMPLE_DIV(DIV), .AVG_LOG2(AL), .ADC_W(W)) dut (
    .clock       (clock),
    .ctrl_reset_n(ctrl_reset_n),
    .enable      (enable),
    .adc_in      (adc_in),
    .ack         (ack),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference: edge t after enable rises adds the ADC value seen two edges earlier when
  // t = k*DIV+1, and publishes the window sum / N when t = m*DIV*N+2.
  logic [31:0] m_data;
  logic        m_ready, m_ovr, m_busy, m_run;
  int          m_t, m_sum, m_h1, m_h2;

  typedef struct {
    logic [3:0][7:0] a;
    logic [31:0]     exp;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_data = '0; m_ready = 0; m_ovr = 0; m_busy = 0; m_run = 0;
    m_t = 0; m_sum = 0; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic model_edge();
    bit pub;
    pub = 0;
    if (!enable) m_run = 0;
    else if (!m_run) begin
      m_run = 1; m_t = 0; m_sum = 0;
    end else begin
      m_t++;
      if (m_t > 2 && (m_t - 2) % (DIV * N) == 0) pub = 1;
      if (m_t > 1 && (m_t - 1) % DIV == 0) m_sum += m_h2;
    end
    if (pub) begin
      m_data = 32'(m_sum / N);
      m_sum = 0;
      m_ovr = m_ready && !ack;
      m_ready = 1;
    end else if (ack && m_ready) begin
      m_ready = 0; m_ovr = 0;
    end
    m_busy = enable;
    m_h2 = m_h1;
    m_h1 = int'(adc_in);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("m_data", sample_data, m_data);
    chk("m_ready", {31'b0, sample_ready}, {31'b0, m_ready});
    chk("m_ovr", {31'b0, overrun}, {31'b0, m_ovr});
    chk("m_busy", {31'b0, busy}, {31'b0, m_busy});
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    enable = 1'b0; ack = 1'b0; adc_in = '0;
    model_reset();
    #1;
    chk("rst_data", sample_data, 32'h0);
    chk("rst_ready", {31'b0, sample_ready}, 32'h0);
    chk("rst_ovr", {31'b0, overrun}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{{8'h80, 8'h80, 8'h80, 8'h80}, 32'h80};
    vt[1] = '{{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 32'hFF};
    vt[2] = '{{8'd41, 8'd30, 8'd20, 8'd10}, 32'h19};
    vt[3] = '{{8'd3, 8'd0, 8'd0, 8'd0}, 32'h0};
    vt[4] = '{{8'd6, 8'd3, 8'd2, 8'd1}, 32'h3};
    vt[5] = '{{8'd1, 8'd255, 8'd0, 8'd255}, 32'h7F};
    #2;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int c = 0; c <= 18; c++) begin
        enable = 1'b1;
        adc_in = vt[i].a[c < 16 ? c / 4 : 3];
        step();
        if (c == 17) chk("vec_pre_ready", {31'b0, sample_ready}, 32'h0);
      end
      chk("vec_data", sample_data, vt[i].exp);
      chk("vec_ready", {31'b0, sample_ready}, 32'h1);
    end

    // async reset mid-window after a publish
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      enable = 1'b1; adc_in = 8'h55;
      step();
    end
    chk("pre_rst_data", sample_data, 32'h55);
    ctrl_reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_data", sample_data, 32'h0);
    chk("mid_rst_ready", {31'b0, sample_ready}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    enable = 1'b0;
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_ready", {31'b0, sample_ready}, 32'h0);

    // overrun, then a single ack clears both flags
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      enable = 1'b1; adc_in = c < 16 ? 8'h20 : 8'h60;
      step();
      if (c == 18) chk("ovr_first_ovr", {31'b0, overrun}, 32'h0);
    end
    chk("ovr_data", sample_data, 32'h60);
    chk("ovr_flag", {31'b0, overrun}, 32'h1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_ready", {31'b0, sample_ready}, 32'h0);
    chk("ack_ovr", {31'b0, overrun}, 32'h0);

    // ack coincident with PUBLISH
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      enable = 1'b1; adc_in = c < 16 ? 8'h10 : 8'h30; ack = (c == 34);
      step();
    end
    ack = 1'b0;
    chk("sim_ready", {31'b0, sample_ready}, 32'h1);
    chk("sim_ovr", {31'b0, overrun}, 32'h0);
    chk("sim_data", sample_data, 32'h30);

    // enable dropped after two captures of the second window
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      enable = 1'b1; adc_in = c < 16 ? 8'h40 : 8'hF0;
      step();
    end
    enable = 1'b0;
    step();
    chk("drop_busy", {31'b0, busy}, 32'h0);
    chk("drop_ready", {31'b0, sample_ready}, 32'h1);
    chk("drop_data", sample_data, 32'h40);
    for (int c = 0; c < 3; c++) step();
    for (int c = 0; c <= 18; c++) begin
      enable = 1'b1; adc_in = 8'(8 * ((c < 16 ? c / 4 : 3) + 1));
      step();
      if (c == 17) chk("reen_old_data", sample_data, 32'h40);
    end
    chk("reen_data", sample_data, 32'h14);
    chk("reen_ovr", {31'b0, overrun}, 32'h1);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      enable = $urandom_range(99) < 97;
      adc_in = 8'($urandom);
      ack = $urandom_range(9) == 0;
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Sequences sampling of the 8-bit external ADC bus (JA) for the register file. It generates the periodic sample strobe, synchronizes and captures the ADC byte, and averages a power-of-two window of samples. It publishes the averaged word with a sticky ready/overrun handshake that the CPU-visible registers (ADC value, ADC-ready) read and acknowledge. It replaces the free-running capture and the standalone 500:1 ready counter.

## Interface

Parameters:
- SAMPLE_DIV, default 500: clock cycles per sample; legal range ≥ 3.
- AVG_LOG2, default 2: log2 of samples per published average; legal range 0..4.
- ADC_W, default 8: ADC bus width.

Ports:
- clock  in  1: single clock; all state on its rising edge.
- ctrl_reset_n  in  1: asynchronous, active-low reset.
- enable  in  1: run sequencer; 0 forces IDLE.
- adc_in  in  ADC_W: raw ADC bus, asynchronous to clock.
- ack  in  1: CPU has consumed sample_data (one-cycle pulse).
- sample_data  out  32: latest average, zero-extended.
- sample_ready  out  1: new sample available, sticky until ack.
- overrun  out  1: a sample was published while sample_ready was still 1.
- busy  out  1: state ≠ IDLE.

## Operation

- adc_in passes through a 2-flop synchronizer. "adc_sync" below means the second flop.
- Divider div counts 0..SAMPLE_DIV-1 and wraps. It runs in every state except IDLE, where it is held at 0.
- Accumulator acc is ADC_W+AVG_LOG2 bits wide and cannot overflow. Sample count n is AVG_LOG2+1 bits.
- FSM states and transitions:
  - IDLE: acc, n and div are 0. enable=1 → COUNT.
  - COUNT: when div==SAMPLE_DIV-1 → CAPTURE.
  - CAPTURE: one cycle. acc ← acc + adc_sync, n ← n+1. If n==2^AVG_LOG2-1 → PUBLISH, else → COUNT.
  - PUBLISH: one cycle. sample_data ← {zeros, acc >> AVG_LOG2}, sample_ready ← 1, acc ← 0, n ← 0. Then → COUNT.
- If enable=0 in any state, the next state is IDLE, and acc, n and div clear. sample_data, sample_ready and overrun are retained.
- ack handling:
  - ack with sample_ready=1 and no publish that cycle: sample_ready ← 0 and overrun ← 0.
  - ack with no publish that cycle and sample_ready=0: ignored.
- Publish with sample_ready=1 and ack=0: overrun ← 1. sample_data is overwritten; the newest sample always wins.
- Publish and ack in the same cycle: sample_ready stays 1, overrun ← 0, and no overrun is flagged.
- busy is combinational from state.

## Timing

- Reset values:
  - state IDLE.
  - sample_data 0, sample_ready 0, overrun 0, busy 0.
  - acc, n, div and both synchronizer flops 0.
- Let edge E0 be the edge that moves IDLE→COUNT.
  - CAPTURE states begin at edges E0 + k·SAMPLE_DIV for k ≥ 1.
  - The sampling period is exactly SAMPLE_DIV, unaffected by CAPTURE/PUBLISH.
- The first sample_ready=1 is visible after edge E0 + 2^AVG_LOG2·SAMPLE_DIV + 2. Subsequent publishes follow every 2^AVG_LOG2·SAMPLE_DIV cycles.
- adc_in must be stable for 2 edges before the edge entering CAPTURE, plus the CAPTURE cycle itself, for a deterministic value.
- ack → sample_ready low on the next edge (1-cycle latency).
- enable low → busy low on the next edge.
- Reset assertion mid-window: immediate return to reset values, no partial publish.

## Structure

- Shared package adc_seq_pkg:
  - state enum (IDLE, COUNT, CAPTURE, PUBLISH).
  - ADC_W default.
  - Register indices for the ADC value and ADC-ready registers.
- One sub-module, adc_input_sync: parameterized-width 2-flop synchronizer with asynchronous active-low clear.
- Divider, FSM, accumulator and handshake stay in the top module.

## Test plan

All scenarios use SAMPLE_DIV=4 and AVG_LOG2=2 unless noted.

- **Reset:** assert ctrl_reset_n=0 mid-COUNT with acc≠0 → all outputs 0 immediately. After release with enable=0, busy stays 0 and sample_ready stays 0.
- **Constant input:** adc_in=0x80, enable at E0 → sample_ready rises after edge E0+18 with sample_data=0x00000080. Repeat with adc_in=0xFF → 0x000000FF, no overflow.
- **Averaging:** adc_in held at 10, 20, 30, 41 across four successive capture windows → sample_data=0x00000019 (101>>2).
- **Overrun:** never ack → second publish sets overrun=1 and sample_data takes the new average. A single ack pulse → sample_ready=0 and overrun=0 on the next edge.
- **Simultaneous ack and publish:** ack coincides with the PUBLISH cycle → sample_ready stays 1, overrun stays 0, sample_data is the new value.
- **Enable dropped mid-window:** drop enable after 2 captures → busy=0 next edge and prior sample_data/sample_ready are retained. Re-enable → next publish averages only the 4 new samples, 18 cycles after re-entry.
